// File: rtl/alu_exec_if.sv
// ---------------------------------------------------------------------------
// alu_exec_if
// Bundles the operation request channel, the result return channel and the
// status outputs of alu_exec_unit.
//
// Both channels use valid/ready semantics: a transfer happens on a rising
// clock edge where valid and ready are both high. Once valid is asserted,
// the producer holds the payload stable until that transfer edge.
//
//   request : in_valid, in_ready, alusel[3:0], a[WIDTH-1:0], b[WIDTH-1:0]
//   result  : out_valid, out_ready, result[WIDTH-1:0],
//             zero, carry, overflow, sign, err
//   status  : busy
//
// master : the side that issues operations and consumes results.
// slave  : the execution unit.
// ---------------------------------------------------------------------------
interface alu_exec_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alusel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             sign;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, alusel, a, b, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow, sign,
               err, busy
    );

    modport slave (
        input  in_valid, alusel, a, b, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow, sign,
               err, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Multi-cycle ALU for the execute stage. Add/sub/logic/compare ops and
// illegal codes finish in one cycle. Shifts are done one bit per cycle, so a
// shift by n takes 1 + n cycles.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : alu_exec_if.slave (request, result and status signals)
//   dbg_state : current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
// Both channels on bus use valid/ready: a transfer happens on a rising edge
// where valid and ready are both high, and the payload is held stable while
// valid waits for ready.
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    alu_exec_if.slave    bus,
    output logic [1:0]   dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    // Shift kind is the low two bits of the shift opcodes.
    localparam logic [1:0] SK_SRL = 2'b00;
    localparam logic [1:0] SK_SLL = 2'b01;
    localparam logic [1:0] SK_SRA = 2'b10;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] acc_q,      acc_d;
    logic [SHW-1:0]   cnt_q,      cnt_d;
    logic [1:0]       kind_q,     kind_d;
    logic             fill_q,     fill_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             zero_q,     zero_d;
    logic             carry_q,    carry_d;
    logic             overflow_q, overflow_d;
    logic             sign_q,     sign_d;
    logic             err_q,      err_d;

    // Single-cycle ALU
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] shift_nxt;

    assign shamt = bus.b[SHW-1:0];

    always_comb begin
        sum_ext   = {1'b0, bus.a} + {1'b0, bus.b};
        diff      = bus.a - bus.b;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        is_shift  = 1'b0;
        case (bus.alusel)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                // Operands share a sign and the sum's sign differs.
                alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff;
                alu_carry = (bus.a >= bus.b);
                // Operands differ in sign and the difference takes b's sign.
                alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_OR:   alu_res = bus.a | bus.b;
            OP_AND:  alu_res = bus.a & bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SRL, OP_SLL, OP_SRA: is_shift = 1'b1;
            default: alu_err = 1'b1;
        endcase
    end

    // One-bit shift step of the accumulator.
    always_comb begin
        case (kind_q)
            SK_SRL:  shift_nxt = {1'b0, acc_q[WIDTH-1:1]};
            SK_SLL:  shift_nxt = {acc_q[WIDTH-2:0], 1'b0};
            SK_SRA:  shift_nxt = {fill_q, acc_q[WIDTH-1:1]};
            default: shift_nxt = acc_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        kind_d     = kind_q;
        fill_d     = fill_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        sign_d     = sign_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = bus.a;
                        cnt_d   = shamt;
                        kind_d  = bus.alusel[1:0];
                        fill_d  = bus.a[WIDTH-1];
                        state_d = ST_SHIFT;
                    end else if (is_shift) begin
                        // Shift by zero passes a straight through.
                        result_d   = bus.a;
                        zero_d     = (bus.a == '0);
                        sign_d     = bus.a[WIDTH-1];
                        carry_d    = 1'b0;
                        overflow_d = 1'b0;
                        err_d      = 1'b0;
                        state_d    = ST_DONE;
                    end else begin
                        // Illegal codes leave alu_res at 0, so zero=1.
                        result_d   = alu_res;
                        zero_d     = (alu_res == '0);
                        sign_d     = alu_res[WIDTH-1];
                        carry_d    = alu_carry;
                        overflow_d = alu_ovf;
                        err_d      = alu_err;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = shift_nxt;
                cnt_d = cnt_q - SHW'(1);
                // The last step lands its value straight in the result.
                if (cnt_q == SHW'(1)) begin
                    result_d   = shift_nxt;
                    zero_d     = (shift_nxt == '0);
                    sign_d     = shift_nxt[WIDTH-1];
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            kind_q     <= SK_SRL;
            fill_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            sign_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            kind_q     <= kind_d;
            fill_q     <= fill_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            sign_q     <= sign_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.sign      = sign_q;
    assign bus.err       = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed and randomized operations on alu_exec_unit, checked against a
// reference model built from plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    localparam int W = 32;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    int n_cmp;
    int n_bad;

    logic [W-1:0] obs_res;

    alu_exec_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns result, carry, overflow, err and latency (cycles from the accept
    // edge, inclusive, to the edge that raises out_valid).
    task automatic model(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic v,
                         output logic e, output int lat);
        longint sa;
        longint sb;
        longint t;
        int     n;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        n   = int'(b[4:0]);
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        e   = 1'b0;
        lat = 1;
        t   = 0;
        case (sel)
            4'b0000: begin
                r = a + b;
                c = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
                t = sa + sb;
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'b0001: begin
                r = a - b;
                c = (a >= b);
                t = sa - sb;
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'b0100: r = a | b;
            4'b0101: r = a & b;
            4'b0111: r = a ^ b;
            4'b1000: begin r = a >> n;           lat = 1 + n; end
            4'b1001: begin r = a << n;           lat = 1 + n; end
            4'b1010: begin r = $signed(a) >>> n; lat = 1 + n; end
            4'b1101: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1111: r = (a < b) ? 32'd1 : 32'd0;
            default: e = 1'b1;
        endcase
    endtask

    // ---------------- driver ----------------
    // Issue one op, check latency/result/flags, then optionally hold the
    // result with out_ready low for 'hold' cycles before handing it off.
    task automatic run_op(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        logic [W-1:0] er;
        logic         ec, ev, ee;
        logic [3:0]   eflg;
        int           elat;
        int           cyc;
        model(sel, a, b, er, ec, ev, ee, elat);
        eflg = {(er == '0), ec, ev, er[W-1]};
        bus.out_ready = (hold == 0);

        cyc = 0;
        while (!bus.in_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("accept_ready", 64'(bus.in_ready), 64'(1));

        bus.in_valid = 1'b1;
        bus.alusel   = sel;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk); #1;
        cyc = 1;
        while (!bus.out_valid && cyc < 100) begin
            chk("busy_while_shift", 64'({bus.in_ready, bus.busy}), 64'(2'b01));
            // New requests while shifting must be ignored.
            bus.in_valid = 1'b1;
            bus.alusel   = 4'($urandom);
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 64'(cyc), 64'(elat));
        chk("result", 64'(bus.result), 64'(er));
        chk("flags_zcvs", 64'({bus.zero, bus.carry, bus.overflow, bus.sign}), 64'(eflg));
        chk("err", 64'(bus.err), 64'(ee));
        obs_res = bus.result;

        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.alusel   = 4'($urandom);
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(posedge clk); #1;
            chk("hold_state", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b101));
            chk("hold_payload",
                64'({bus.result, bus.zero, bus.carry, bus.overflow, bus.sign, bus.err}),
                64'({er, eflg, ee}));
        end

        // Handoff edge; a request presented here must not be accepted.
        bus.in_valid  = 1'b1;
        bus.alusel    = 4'b0000;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("handoff_state", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b010));
        chk("after_handoff_result", 64'(bus.result), 64'(er));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, 64'({bus.in_ready, bus.busy, bus.out_valid, bus.result, bus.zero,
                      bus.carry, bus.overflow, bus.sign, bus.err}),
            64'({1'b1, 1'b0, 1'b0, 32'h0, 5'b0}));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0]   sel;
        logic [W-1:0] ra, rb;
        int           hold;
        n_cmp = 0;
        n_bad = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alusel    = 4'b0000;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset_values");
        chk("reset_dbg_state", 64'(dbg_state), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("release_in_ready", 64'(bus.in_ready), 64'(1));

        // add overflow
        run_op(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        chk("add_ovf_const", 64'(obs_res), 64'(32'h8000_0000));
        // sub equal and sub negative
        run_op(4'b0001, 32'd5, 32'd5, 0);
        chk("sub_eq_const", 64'(obs_res), 64'(0));
        run_op(4'b0001, 32'd3, 32'd5, 0);
        chk("sub_neg_const", 64'(obs_res), 64'(32'hFFFF_FFFE));
        // sra with shamt 4 (upper b bits ignored)
        run_op(4'b1010, 32'h8000_0000, 32'h0000_0024, 0);
        chk("sra_const", 64'(obs_res), 64'(32'hF800_0000));
        // sll shamt 0, slt, sltu
        run_op(4'b1001, 32'h0000_1234, 32'h0000_0020, 0);
        chk("sll0_const", 64'(obs_res), 64'(32'h1234));
        run_op(4'b1101, 32'hFFFF_FFFF, 32'd1, 0);
        chk("slt_const", 64'(obs_res), 64'(1));
        run_op(4'b1111, 32'hFFFF_FFFF, 32'd1, 0);
        chk("sltu_const", 64'(obs_res), 64'(0));
        // illegal code under backpressure
        run_op(4'b0011, 32'h1234_5678, 32'h9ABC_DEF0, 10);
        // shift by WIDTH-1 (worst case)
        run_op(4'b1000, 32'hFFFF_FFFF, 32'd31, 1);

        // reset during a shift
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.alusel    = 4'b1000;
        bus.a         = 32'hDEAD_BEEF;
        bus.b         = 32'd20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("midshift_busy", 64'(bus.busy), 64'(1));
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset_midshift");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_no_out_valid", 64'(bus.out_valid), 64'(0));
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("post_reset_idle");
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            chk("no_stale_result", 64'(bus.out_valid), 64'(0));
        end
        run_op(4'b0000, 32'd100, 32'd23, 0);

        // randomized operations
        for (int k = 0; k < 250; k++) begin
            sel  = 4'($urandom_range(0, 15));
            ra   = $urandom;
            rb   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = ra;
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(sel, ra, rb, hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
